// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: verifies the PLL output frequency over fixed refclk windows and gates the downstream reset.
// Defining PLL_LOCK_MON_WDOG_EN adds a stall watchdog on mon_clk that is active only while in RUN.
module pll_lock_monitor #(
  parameter int unsigned WINDOW       = 3000,
  parameter int unsigned EXP_EDGES    = 1000,
  parameter int unsigned TOL          = 10,
  parameter int unsigned GOOD_WINDOWS = 4,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STALL        = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             pll_locked,
  input  logic             fault_clr,
  output logic             sys_rst,
  output logic             clk_ok,
  output logic             fault,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_MEASURE   = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_FAULT     = 2'd3;

  localparam int unsigned GW = $clog2(GOOD_WINDOWS + 1);

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W:0]   LO_BOUND  = (CNT_W+1)'(EXP_EDGES - TOL);
  localparam logic [CNT_W:0]   HI_BOUND  = (CNT_W+1)'(EXP_EDGES + TOL);
  localparam logic [GW-1:0]    GOOD_LAST = GW'(GOOD_WINDOWS - 1);
  localparam logic [GW-1:0]    GOOD_MAX  = GW'(GOOD_WINDOWS);

  if (EXP_EDGES < TOL || GOOD_WINDOWS == 0 || WINDOW == 0 || STALL == 0) begin : g_param_check
    $error("pll_lock_monitor: invalid parameter set");
  end

  // Input conditioning
  logic lk_s1_q, lk_s2_q;
  logic mc_s1_q, mc_s2_q, mc_s3_q;
  logic edge_rise;

  // Control and measurement state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [GW-1:0]    good_q, good_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sys_rst_q, sys_rst_d;
  logic             clk_ok_q, clk_ok_d;
  logic             fault_q, fault_d;

  logic             win_end;
  logic             win_good;
  logic             good_reach;
  logic             counting;
  logic             stall_trip;
  logic [CNT_W-1:0] edge_sat_inc;
  logic [CNT_W-1:0] edge_total;
  logic [GW-1:0]    good_next;

  assign edge_rise = mc_s2_q & ~mc_s3_q;
  assign win_end   = (win_q == WIN_LAST);
  assign counting  = (state_q == S_MEASURE) || (state_q == S_RUN);

  // The window-end count must include the edge arriving in that same cycle.
  assign edge_sat_inc = (edge_q == '1) ? edge_q : edge_q + 1'b1;
  assign edge_total   = edge_rise ? edge_sat_inc : edge_q;

  assign win_good   = ({1'b0, edge_total} >= LO_BOUND) && ({1'b0, edge_total} <= HI_BOUND);
  assign good_next  = win_good ? ((good_q == GOOD_MAX) ? good_q : good_q + 1'b1) : '0;
  assign good_reach = win_good && (good_q >= GOOD_LAST);

`ifdef PLL_LOCK_MON_WDOG_EN
  localparam int unsigned SW = $clog2(STALL + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL - 1);

  logic [SW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = '0;
    if (state_q == S_RUN && !edge_rise) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Tripping as the counter would reach STALL puts FAULT exactly STALL cycles after the last counted edge.
  assign stall_trip = (state_q == S_RUN) && !edge_rise && (stall_q == STALL_LAST);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign stall_trip = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    edge_d     = edge_q;
    good_d     = good_q;
    edge_cnt_d = edge_cnt_q;

    if (state_q == S_WAIT_LOCK) begin
      win_d  = '0;
      edge_d = '0;
      good_d = '0;
    end else if (counting) begin
      if (win_end) begin
        win_d      = '0;
        edge_d     = '0;
        edge_cnt_d = edge_total;
        good_d     = good_next;
      end else begin
        win_d  = win_q + 1'b1;
        edge_d = edge_total;
      end
    end

    case (state_q)
      S_WAIT_LOCK: begin
        if (lk_s2_q) begin
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (!lk_s2_q) begin
          state_d = S_WAIT_LOCK;
        end else if (win_end && good_reach) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!lk_s2_q || (win_end && !win_good) || stall_trip) begin
          state_d = S_FAULT;
        end
      end
      default: begin
        if (fault_clr) begin
          state_d = S_WAIT_LOCK;
        end
      end
    endcase

    // Outputs follow the next state so they switch on the same edge as the state register.
    sys_rst_d = (state_d != S_RUN);
    clk_ok_d  = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_s1_q    <= 1'b0;
      lk_s2_q    <= 1'b0;
      mc_s1_q    <= 1'b0;
      mc_s2_q    <= 1'b0;
      mc_s3_q    <= 1'b0;
      state_q    <= S_WAIT_LOCK;
      win_q      <= '0;
      edge_q     <= '0;
      good_q     <= '0;
      edge_cnt_q <= '0;
      sys_rst_q  <= 1'b1;
      clk_ok_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      lk_s1_q    <= pll_locked;
      lk_s2_q    <= lk_s1_q;
      mc_s1_q    <= mon_clk;
      mc_s2_q    <= mc_s1_q;
      mc_s3_q    <= mc_s2_q;
      state_q    <= state_d;
      win_q      <= win_d;
      edge_q     <= edge_d;
      good_q     <= good_d;
      edge_cnt_q <= edge_cnt_d;
      sys_rst_q  <= sys_rst_d;
      clk_ok_q   <= clk_ok_d;
      fault_q    <= fault_d;
    end
  end

  assign sys_rst  = sys_rst_q;
  assign clk_ok   = clk_ok_q;
  assign fault    = fault_q;
  assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor using a scaled window (300 cycles, 100 +/- 10 edges, 4 good windows).
// mon_clk pulses are injected as refclk-aligned bursts placed well inside each measurement window.
module tb_pll_lock_monitor;

  localparam int unsigned WINDOW = 300;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        mon_clk = 1'b0;
  logic        pll_locked = 1'b0;
  logic        fault_clr = 1'b0;
  logic        sys_rst;
  logic        clk_ok;
  logic        fault;
  logic [15:0] edge_cnt;

  int errors = 0;
  int checks = 0;

  always #10 refclk = ~refclk;

  pll_lock_monitor #(
    .WINDOW(WINDOW),
    .EXP_EDGES(100),
    .TOL(10),
    .GOOD_WINDOWS(4),
    .CNT_W(16),
    .STALL(16)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .mon_clk(mon_clk),
    .pll_locked(pll_locked),
    .fault_clr(fault_clr),
    .sys_rst(sys_rst),
    .clk_ok(clk_ok),
    .fault(fault),
    .edge_cnt(edge_cnt)
  );

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge refclk);
      mon_clk = 1'b0;
    end
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      @(negedge refclk);
      mon_clk = 1'b1;
      @(negedge refclk);
      mon_clk = 1'b0;
    end
  endtask

  // Spans exactly one window; returns at the negedge just before the window-end edge.
  task automatic run_window(input int n);
    idle(20);
    pulses(n);
    idle(WINDOW - 20 - 2 * n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b want 1", sys_rst); end
    checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL reset_clk_ok: got %b want 0", clk_ok); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (edge_cnt !== 16'd0) begin errors++; $display("FAIL reset_edge_cnt: got %0d want 0", edge_cnt); end
    @(negedge refclk);
    rst = 1'b0;
    fault_clr = 1'b1;
    @(negedge refclk);
    fault_clr = 1'b0;
    repeat (5) @(posedge refclk);
    #1;
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL nolock_sys_rst: got %b want 1", sys_rst); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL clr_ignored_fault: got %b want 0", fault); end
  endtask

  task automatic test_nominal;
    @(negedge refclk);
    pll_locked = 1'b1;
    repeat (3) @(posedge refclk);
    for (int w = 0; w < 4; w++) begin
      run_window(100);
      if (w == 3) begin
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL nom_early_release: got %b want 1", sys_rst); end
      end
      @(posedge refclk);
      #1;
      checks++; if (edge_cnt !== 16'd100) begin errors++; $display("FAIL nom_edge_cnt w%0d: got %0d want 100", w, edge_cnt); end
      checks++; if (sys_rst !== (w != 3)) begin errors++; $display("FAIL nom_sys_rst w%0d: got %b want %b", w, sys_rst, w != 3); end
      checks++; if (clk_ok !== (w == 3)) begin errors++; $display("FAIL nom_clk_ok w%0d: got %b want %b", w, clk_ok, w == 3); end
    end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL nom_fault: got %b want 0", fault); end
  endtask

  task automatic test_lock_loss;
    @(negedge refclk);
    pll_locked = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge refclk);
      #1;
      checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL loss_early_sys_rst e%0d: got %b want 0", k, sys_rst); end
    end
    @(posedge refclk);
    #1;
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL loss_sys_rst: got %b want 1", sys_rst); end
    checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL loss_clk_ok: got %b want 0", clk_ok); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL loss_fault: got %b want 1", fault); end
    repeat (5) @(posedge refclk);
    #1;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL loss_sticky: got %b want 1", fault); end
    @(negedge refclk);
    fault_clr = 1'b1;
    @(negedge refclk);
    fault_clr = 1'b0;
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL clr_fault: got %b want 0", fault); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL clr_sys_rst: got %b want 1", sys_rst); end
    repeat (3) @(posedge refclk);
    #1;
    checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL clr_clk_ok: got %b want 0", clk_ok); end
  endtask

  task automatic test_off_freq;
    @(negedge refclk);
    pll_locked = 1'b1;
    repeat (3) @(posedge refclk);
    for (int w = 0; w < 5; w++) begin
      run_window(120);
      @(posedge refclk);
      #1;
      checks++; if (edge_cnt !== 16'd120) begin errors++; $display("FAIL off_edge_cnt w%0d: got %0d want 120", w, edge_cnt); end
      checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL off_sys_rst w%0d: got %b want 1", w, sys_rst); end
    end
  endtask

  task automatic test_tolerance;
    int cnts[12] = '{90, 110, 90, 89, 110, 90, 110, 111, 90, 110, 90, 110};
    for (int i = 0; i < 12; i++) begin
      run_window(cnts[i]);
      @(posedge refclk);
      #1;
      checks++; if (edge_cnt !== 16'(cnts[i])) begin errors++; $display("FAIL tol_edge_cnt i%0d: got %0d want %0d", i, edge_cnt, cnts[i]); end
      checks++; if (sys_rst !== (i != 11)) begin errors++; $display("FAIL tol_sys_rst i%0d: got %b want %b", i, sys_rst, i != 11); end
    end
  endtask

  task automatic test_stopped_clock;
`ifdef PLL_LOCK_MON_WDOG_EN
    idle(20);
    pulses(40);
    repeat (17) @(posedge refclk);
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wdog_early_fault: got %b want 0", fault); end
    @(posedge refclk);
    #1;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL wdog_fault: got %b want 1", fault); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL wdog_sys_rst: got %b want 1", sys_rst); end
`else
    run_window(40);
    checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL stop_early_sys_rst: got %b want 0", sys_rst); end
    @(posedge refclk);
    #1;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL stop_fault: got %b want 1", fault); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL stop_sys_rst: got %b want 1", sys_rst); end
    checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL stop_clk_ok: got %b want 0", clk_ok); end
    checks++; if (edge_cnt !== 16'd40) begin errors++; $display("FAIL stop_edge_cnt: got %0d want 40", edge_cnt); end
`endif
  endtask

  task automatic test_reset_mid_window;
    @(negedge refclk);
    #2 rst = 1'b1;
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL arst_fault: got %b want 0", fault); end
    checks++; if (edge_cnt !== 16'd0) begin errors++; $display("FAIL arst_edge_cnt: got %0d want 0", edge_cnt); end
    @(negedge refclk);
    rst = 1'b0;
    repeat (3) @(posedge refclk);
    for (int w = 0; w < 2; w++) begin
      run_window(100);
      @(posedge refclk);
      #1;
      checks++; if (edge_cnt !== 16'd100) begin errors++; $display("FAIL mid_pre_edge_cnt w%0d: got %0d want 100", w, edge_cnt); end
    end
    idle(20);
    pulses(30);
    #3 rst = 1'b1;
    #1;
    checks++; if (edge_cnt !== 16'd0) begin errors++; $display("FAIL mid_edge_cnt: got %0d want 0", edge_cnt); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL mid_sys_rst: got %b want 1", sys_rst); end
    checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL mid_clk_ok: got %b want 0", clk_ok); end
    @(negedge refclk);
    rst = 1'b0;
    repeat (3) @(posedge refclk);
    for (int w = 0; w < 4; w++) begin
      run_window(100);
      @(posedge refclk);
      #1;
      checks++; if (sys_rst !== (w != 3)) begin errors++; $display("FAIL mid_release w%0d: got %b want %b", w, sys_rst, w != 3); end
    end
    checks++; if (clk_ok !== 1'b1) begin errors++; $display("FAIL mid_clk_ok_final: got %b want 1", clk_ok); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_off_freq();
    test_tolerance();
    test_stopped_clock();
    test_reset_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

- Consumer-side companion to the PLL wrapper; runs in the `refclk` domain.
- Takes the PLL's `locked` and its output clock, and checks that the output clock really runs at the configured frequency by counting its edges over fixed refclk windows.
- Holds the downstream system reset until the clock has been verified for several consecutive windows.
- Flags a sticky fault if the lock is lost or the frequency leaves tolerance.

## Interface

Parameters:
- `WINDOW`, 3000: measurement window length in refclk cycles (60 µs at 50 MHz).
- `EXP_EDGES`, 1000: expected `mon_clk` rising edges per window (16.666 MHz × 60 µs).
- `TOL`, 10: allowed deviation in edges; `EXP_EDGES >= TOL` is required.
- `GOOD_WINDOWS`, 4: consecutive in-tolerance windows needed before release.
- `CNT_W`, 16: width of edge and window counters.
- `STALL`, 16: refclk cycles without a `mon_clk` edge that trip the watchdog (see Configuration).

Ports:
- `refclk`, input, 1: sole clock, 50 MHz.
- `rst`, input, 1: asynchronous, active-high reset.
- `mon_clk`, input, 1: PLL output clock, sampled as asynchronous data.
- `pll_locked`, input, 1: PLL `locked`, asynchronous.
- `fault_clr`, input, 1: refclk-synchronous pulse; clears the fault.
- `sys_rst`, output, 1: active-high downstream reset.
- `clk_ok`, output, 1: clock verified and running.
- `fault`, output, 1: sticky fault flag.
- `edge_cnt`, output, `CNT_W`: edge count of the last completed window.

## Operation

Input conditioning:
- `mon_clk` and `pll_locked` each pass through a 2-flop synchronizer.
- A third flop on `mon_clk` gives the rising edge: `e = s2 & ~s3`.

Counters:
- Window counter runs 0..`WINDOW-1` and wraps. It is cleared whenever the state is `WAIT_LOCK`.
- Edge counter increments on `e` and saturates at 2^`CNT_W`-1.
- On the last window cycle the count includes that cycle's `e`. At that cycle the count is latched into `edge_cnt` and the counter restarts at 0, or at 1 if `e` was set in the first cycle of the new window.
- A window is good iff `EXP_EDGES-TOL <= count <= EXP_EDGES+TOL` (unsigned, both bounds inclusive).
- `good_cnt` increments on a good window and resets to 0 on a bad one.

State machine:
- `WAIT_LOCK`
  - Outputs: `sys_rst`=1, `clk_ok`=0.
  - Synchronized lock = 1 → `MEASURE`, with all counters cleared.
- `MEASURE`
  - Outputs: `sys_rst`=1, `clk_ok`=0.
  - Synchronized lock = 0 → `WAIT_LOCK`.
  - Window end with `good_cnt` reaching `GOOD_WINDOWS` → `RUN`.
- `RUN`
  - Outputs: `sys_rst`=0, `clk_ok`=1.
  - Lock = 0, a bad window, or a watchdog trip → `FAULT`.
- `FAULT`
  - Outputs: `sys_rst`=1, `clk_ok`=0, `fault`=1.
  - `fault_clr` → `WAIT_LOCK`, with `fault`=0.

Priorities and ignored inputs:
- Loss of lock has priority over a simultaneous window end.
- In `FAULT`, `fault_clr` has priority over everything else.
- `fault_clr` is ignored outside `FAULT`.

Reset:
- Reset values: `sys_rst`=1, `clk_ok`=0, `fault`=0, `edge_cnt`=0, state `WAIT_LOCK`, all counters 0.
- Asserting `rst` at any time, including mid-window, forces these values immediately (asynchronously).

## Timing

- All outputs are registered and change together with the state register.
- `pll_locked` changing before refclk edge k → state and outputs change at edge k+2.
- `mon_clk` rising edge sampled at edge k → counted at edge k+2.
- Release: in `MEASURE`, `sys_rst` falls and `clk_ok` rises at the edge that latches the `GOOD_WINDOWS`-th good `edge_cnt`.
  - Minimum time from synchronized lock is `GOOD_WINDOWS`×`WINDOW` cycles plus 1 (12001 cycles with defaults).
- Loss of lock in `RUN` → `sys_rst`=1 and `fault`=1 at edge k+2. There are no intermediate cycles in which `sys_rst`=0 after the lock is lost.
- `mon_clk` must not exceed `refclk`/2.5; faster clocks undercount. This is a documented limitation; no detection is provided.

## Configuration

- Macro `PLL_LOCK_MON_WDOG_EN`.
- Defined:
  - A stall counter runs in `RUN` only.
  - It is cleared on every `e` and increments otherwise.
  - Reaching `STALL` → `FAULT` on the next edge.
- Undefined:
  - There is no stall counter.
  - A stopped clock is detected only at the next window end, as a bad window with count 0.

## Test plan

1. **Nominal release:** `pll_locked`=1, `mon_clk` with a 60 ns period → `edge_cnt`=1000 each window; `sys_rst` falls and `clk_ok` rises after 4 windows; `fault`=0.
2. **Off-frequency clock:** `mon_clk` at 20 MHz → `edge_cnt`=1200 every window; remains in `MEASURE`; `sys_rst` stays 1 indefinitely.
3. **Tolerance boundaries:** bench injects exactly 990 and 1010 edges per window → accepted. 989 or 1011 → `good_cnt` resets, and release is delayed by a full 4 further windows.
4. **Lock loss in `RUN`:** drop `pll_locked` → `sys_rst`=1, `clk_ok`=0, `fault`=1 two edges later. Then pulse `fault_clr` with lock still low → `WAIT_LOCK`, `fault`=0.
5. **Stopped clock in `RUN`:** hold `mon_clk` low.
   - With `PLL_LOCK_MON_WDOG_EN` → `FAULT` 16 cycles after the last counted edge.
   - Without it → `FAULT` at the window end, with `edge_cnt` holding that window's (partial) count.
6. **Reset mid-window:** assert `rst` mid-window in `MEASURE` (`good_cnt`=2) → outputs return to reset values with no clock edge. After release, the full 4 windows are required again.
